// File: rtl/elastic_pipeline_pkg.sv
// elastic_pipeline_pkg
// Shared defaults for the elastic pipeline and the width helper for its
// optional occupancy counter.
//   XLEN_DEF   : default payload width
//   DEPTH_DEF  : default number of register stages
//   occ_width  : bits needed to count 0..depth valid stages
package elastic_pipeline_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 4;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage
// One valid/data slice of the elastic pipeline.
// Ports:
//   clock, resetn     : rising-edge clock, asynchronous active-low reset
//   en_i              : global enable (low while stalled or flushing)
//   clr_i             : synchronous discard of the held beat
//   up_valid_i/data_i : beat offered by the previous stage (or the input port)
//   dn_ready_i        : next stage (or output port) can take a beat
//   ready_o           : this slice can load a beat this cycle
//   valid_o/data_o    : held beat
// The payload register only loads when a valid beat arrives, so an empty
// slice keeps showing the last payload it carried.
module pipe_stage
  import elastic_pipeline_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            up_valid_i,
  input  logic [XLEN-1:0] up_data_i,
  input  logic            dn_ready_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q,  data_d;

  // Empty slices always accept; a full slice accepts when its beat moves on.
  assign ready_o = !valid_q || dn_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (en_i && ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = up_data_i;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline
// DEPTH-stage, XLEN-wide register pipeline with valid/ready on both ends,
// bubble collapse under backpressure, a global stall and a synchronous flush.
// Ports:
//   clock, resetn          : rising-edge clock, asynchronous active-low reset
//   stall                  : freeze every stage, no transfers on either port
//   flush                  : discard all in-flight beats at the next edge
//   in_valid/in_data       : upstream beat
//   in_ready               : beat is accepted this cycle
//   out_valid/out_data     : beat held in the last stage
//   out_ready              : downstream accepts this cycle
//   occupancy              : count of valid stages (only with PIPE_OCCUPANCY_EN)
// Build option: define PIPE_OCCUPANCY_EN to add the registered occupancy
// counter and its bound check.
//
// Handshake: a transfer happens on a port in a cycle where its valid and
// ready are both 1 at the rising edge. in_ready already folds in stall,
// flush and reset; an output transfer additionally needs !stall && !flush.
// Once out_valid is 1 it stays 1 with stable out_data until the beat is
// taken, except on flush or reset.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  input  logic            out_ready
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  logic stage_en;

  // Flush has priority over stall: the slices clear on flush regardless of en.
  assign stage_en = !stall && !flush;

  // Each generate scope owns its own handshake wires, so the ready chain
  // (last stage back to stage 0) is a plain combinational path between
  // distinct signals.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic            up_valid;
    logic [XLEN-1:0] up_data;
    logic            dn_ready;
    logic            st_ready;
    logic            st_valid;
    logic [XLEN-1:0] st_data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = g_stage[i-1].st_valid;
      assign up_data  = g_stage[i-1].st_data;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_link
      assign dn_ready = g_stage[i+1].st_ready;
    end

    pipe_stage #(
      .XLEN(XLEN)
    ) u_stage (
      .clock      (clock),
      .resetn     (resetn),
      .en_i       (stage_en),
      .clr_i      (flush),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .dn_ready_i (dn_ready),
      .ready_o    (st_ready),
      .valid_o    (st_valid),
      .data_o     (st_data)
    );
  end

  // resetn is folded in so in_ready reads 0 for the whole reset interval.
  assign in_ready  = g_stage[0].st_ready && stage_en && resetn;
  assign out_valid = g_stage[DEPTH-1].st_valid;
  assign out_data  = g_stage[DEPTH-1].st_data;

`ifdef PIPE_OCCUPANCY_EN
  localparam int unsigned OCCW = occ_width(DEPTH);

  logic [OCCW-1:0] occ_q, occ_d;
  logic            push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && stage_en;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (push && !pop) begin
      occ_d = occ_q + OCCW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCCW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

  occ_bound_a : assert property (@(posedge clock) disable iff (!resetn)
                                 32'(occ_q) <= DEPTH);
`endif

endmodule
